// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch control encodings and the PSR0 select decode
package fetch_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_REQ, S_LATCH, S_ISSUE, S_VECT, S_ERR} state_e;
  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [1:0] PC_CLR  = 2'b11;
  localparam logic [1:0] SEL_0_7 = 2'b00;
  localparam logic [1:0] SEL_8_B = 2'b01;
  localparam logic [1:0] SEL_C_D = 2'b10;
  localparam logic [1:0] SEL_E_F = 2'b11;
  function automatic logic [1:0] psr0_sel_of(input logic [3:0] op);
    return !op[3] ? SEL_0_7 : !op[2] ? SEL_8_B : !op[1] ? SEL_C_D : SEL_E_F;
  endfunction
endpackage

// File: rtl/miss_timer.sv
// miss_timer: cache wait counter with clear, enable and terminal-count compare
module miss_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = LIMIT < 1 ? 1 : $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // clear wins over counting
  always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign tc = cnt_q == W'(LIMIT);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer feeding PSR0 with interrupt vectoring and cache timeout
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int MISS_LIMIT = 15
) (
  input  logic       g_clk,
  input  logic       g_clr,
  input  logic       i_odv,
  input  logic       stall,
  input  logic       i_pending,
  input  logic       iret,
  input  logic [3:0] ir_op,
  output logic       cache_rw,
  output logic       cache_cs,
  output logic       ir_ld,
  output logic       imar_ld,
  output logic [1:0] pc_ctl,
  output logic [1:0] psr0_sel,
  output logic       psr0_ld,
  output logic       i_en,
  output logic       fetch_err,
  output logic [7:0] fetch_count
);
  state_e state_q, state_d;
  logic i_en_q, i_en_d;
  logic [7:0] cnt_q, cnt_d;
  logic take_int, tmr_clr, tmr_en, tmr_tc;
  miss_timer #(.LIMIT(MISS_LIMIT)) u_timer (
    .clk(g_clk), .rst(g_clr), .clr(tmr_clr), .en(tmr_en), .tc(tmr_tc)
  );
  // next state and strobes, decoded from the registered state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cache_rw = 1'b0;
    cache_cs = 1'b0;
    ir_ld    = 1'b0;
    imar_ld  = 1'b0;
    pc_ctl   = PC_HOLD;
    psr0_sel = SEL_0_7;
    psr0_ld  = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    take_int = i_pending && i_en_q;
    case (state_q)
      S_IDLE: begin
        pc_ctl  = PC_CLR;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        tmr_clr = 1'b1;
        imar_ld = !take_int;
        pc_ctl  = take_int ? PC_LOAD : PC_INC;
        state_d = take_int ? S_VECT : S_REQ;
      end
      S_VECT: begin
        imar_ld = 1'b1;
        pc_ctl  = PC_INC;
        state_d = S_REQ;
      end
      S_REQ: begin
        cache_cs = 1'b1;
        cache_rw = 1'b1;
        tmr_en   = !i_odv;
        state_d  = i_odv ? S_LATCH : tmr_tc ? S_ERR : S_REQ;
      end
      S_LATCH: begin
        ir_ld   = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        psr0_sel = psr0_sel_of(ir_op);
        psr0_ld  = !stall;
        cnt_d    = stall ? cnt_q : cnt_q + 8'd1;
        state_d  = stall ? S_ISSUE : S_ADDR;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    i_en_d = (state_q == S_ADDR && take_int) ? 1'b0 : (iret && state_q != S_ERR) ? 1'b1 : i_en_q;
  end
  // state, interrupt enable and issue counter registers
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state_q <= S_IDLE;
      i_en_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      i_en_q  <= i_en_d;
      cnt_q   <= cnt_d;
    end
  end
  assign i_en        = i_en_q;
  assign fetch_err   = state_q == S_ERR;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  logic g_clk = 1'b0, g_clr = 1'b1, i_odv = 1'b1, stall = 1'b0, i_pending = 1'b0, iret = 1'b0;
  logic [3:0] ir_op = 4'h0;
  logic cache_rw, cache_cs, ir_ld, imar_ld, psr0_ld, i_en, fetch_err;
  logic [1:0] pc_ctl, psr0_sel;
  logic [7:0] fetch_count;
  int checks = 0, failures = 0, cs_n, ir_n;
  logic [3:0] ops [8] = '{4'h3, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h8, 4'h7};
  logic [1:0] sels [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0};
  always #5 g_clk = ~g_clk;
  fetch_ctrl #(.MISS_LIMIT(15)) dut (
    .g_clk(g_clk), .g_clr(g_clr), .i_odv(i_odv), .stall(stall), .i_pending(i_pending),
    .iret(iret), .ir_op(ir_op), .cache_rw(cache_rw), .cache_cs(cache_cs), .ir_ld(ir_ld),
    .imar_ld(imar_ld), .pc_ctl(pc_ctl), .psr0_sel(psr0_sel), .psr0_ld(psr0_ld), .i_en(i_en),
    .fetch_err(fetch_err), .fetch_count(fetch_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge g_clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    tick(2);
    #1;
    check("rst_pc", pc_ctl, 3);
    check("rst_ien", i_en, 1);
    check("rst_err", fetch_err, 0);
    check("rst_cnt", fetch_count, 0);
    check("rst_cs", cache_cs, 0);
    check("rst_psr", psr0_ld, 0);
    g_clr = 1'b0;
    tick; #1;
    check("addr_imar", imar_ld, 1);
    check("addr_pc", pc_ctl, 1);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin tick; #1; end
      check("thru_ld", psr0_ld, (i % 4 == 3) ? 1 : 0);
    end
    tick; #1;
    check("thru_cnt", fetch_count, 3);
    check("thru_addr", imar_ld, 1);
    i_odv = 1'b0; cs_n = 0; ir_n = 0;
    for (int n = 0; n < 8; n++) begin
      tick;
      if (n == 5) i_odv = 1'b1;
      #1;
      cs_n += int'(cache_cs);
      ir_n += int'(ir_ld);
    end
    check("miss_cs", cs_n, 6);
    check("miss_ir", ir_n, 1);
    tick; #1;
    check("miss_cnt", fetch_count, 4);
    ir_op = 4'h9;
    tick(2);
    stall = 1'b1;
    #1;
    check("stl_irld", ir_ld, 1);
    for (int k = 0; k < 3; k++) begin
      tick; #1;
      check("stl_sel", psr0_sel, 1);
      check("stl_ld", psr0_ld, 0);
      check("stl_pc", pc_ctl, 0);
    end
    for (int k = 0; k < 8; k++) begin
      tick;
      ir_op = ops[k];
      #1;
      check("dec_sel", psr0_sel, sels[k]);
    end
    check("stl_cnt", fetch_count, 4);
    tick;
    ir_op = 4'h9; stall = 1'b0;
    #1;
    check("rel_ld", psr0_ld, 1);
    check("rel_sel", psr0_sel, 1);
    tick; #1;
    check("rel_cnt", fetch_count, 5);
    i_pending = 1'b1;
    #1;
    check("int_pc", pc_ctl, 2);
    check("int_imar", imar_ld, 0);
    tick; #1;
    check("int_ien", i_en, 0);
    check("vect_pc", pc_ctl, 1);
    check("vect_imar", imar_ld, 1);
    tick(4); #1;
    check("ign_pc", pc_ctl, 1);
    check("ign_ien", i_en, 0);
    check("ign_cnt", fetch_count, 6);
    tick(3);
    iret = 1'b1;
    tick;
    iret = 1'b0;
    #1;
    check("iret_ien", i_en, 1);
    check("int2_pc", pc_ctl, 2);
    tick;
    i_pending = 1'b0;
    #1;
    check("int2_ien", i_en, 0);
    tick(4); #1;
    check("int2_cnt", fetch_count, 8);
    i_odv = 1'b0;
    tick(16);
    i_odv = 1'b1;
    #1;
    check("win_cs", cache_cs, 1);
    tick; #1;
    check("win_ir", ir_ld, 1);
    check("win_err", fetch_err, 0);
    tick(2);
    i_odv = 1'b0;
    tick(16); #1;
    check("to_cs", cache_cs, 1);
    check("to_err0", fetch_err, 0);
    tick; #1;
    check("to_err1", fetch_err, 1);
    check("to_cs0", cache_cs, 0);
    i_odv = 1'b1; iret = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick; #1;
      check("err_hold", fetch_err, 1);
      check("err_ien", i_en, 0);
      check("err_cs", cache_cs, 0);
      check("err_pc", pc_ctl, 0);
    end
    check("err_cnt", fetch_count, 9);
    g_clr = 1'b1; iret = 1'b0;
    tick; #1;
    check("clr_err", fetch_err, 0);
    check("clr_pc", pc_ctl, 3);
    check("clr_ien", i_en, 1);
    check("clr_cnt", fetch_count, 0);
    g_clr = 1'b0;
    tick;
    tick(255 * 4); #1;
    check("wrap_255", fetch_count, 255);
    tick(4); #1;
    check("wrap_0", fetch_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
